// File: rtl/sd_stream_packer.sv
// Packs a strobed byte stream into WORD_BYTES-wide words and buffers them in a FWFT FIFO
// drained over valid/ready. Define SD_PACK_CHECKSUM_EN to add the running mod-256 byte checksum.
module sd_stream_packer #(
  parameter int unsigned WORD_BYTES      = 4,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter bit          BIG_ENDIAN      = 1'b0,
  parameter logic [7:0]  PAD_BYTE        = 8'h00
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_en,
  input  logic [7:0]                  in_byte,
  input  logic                        flush,
  output logic                        o_tvalid,
  input  logic                        o_tready,
  output logic [8*WORD_BYTES-1:0]     o_tdata,
  output logic                        o_tlast,
  output logic [FIFO_DEPTH_LOG2:0]    fifo_level,
  output logic                        overflow,
  output logic [31:0]                 byte_count
`ifdef SD_PACK_CHECKSUM_EN
  ,
  output logic [7:0]                  checksum
`endif
);

  localparam int unsigned W     = 8 * WORD_BYTES;
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned IDXW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned PW    = FIFO_DEPTH_LOG2;
  localparam int unsigned LW    = FIFO_DEPTH_LOG2 + 1;

  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    pack_q, pack_d;
  logic [W-1:0]    word_fill, word_push;
  logic [IDXW:0]   fill_cnt;
  logic            word_done, push, push_ok, pop, fifo_full;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     bcnt_q, bcnt_d;
  logic [W:0]      mem [DEPTH];

  // Physical lane for the i-th byte of a word.
  function automatic int unsigned lane_pos(input int unsigned i);
    return BIG_ENDIAN ? (WORD_BYTES - 1 - i) : i;
  endfunction

  assign word_done = in_en && (idx_q == IDXW'(WORD_BYTES - 1));
  assign push      = word_done || flush;

  // The current byte is merged before padding, so a flush closes the word it arrives with.
  always_comb begin
    word_fill = pack_q;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (in_en && (idx_q == IDXW'(i))) begin
        word_fill[8*lane_pos(i) +: 8] = in_byte;
      end
    end
    fill_cnt  = {1'b0, idx_q} + (IDXW+1)'(in_en);
    word_push = word_fill;
    if (flush) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        if ((IDXW+1)'(i) >= fill_cnt) begin
          word_push[8*lane_pos(i) +: 8] = PAD_BYTE;
        end
      end
    end
  end

  always_comb begin
    idx_d  = idx_q;
    pack_d = pack_q;
    if (push) begin
      idx_d  = '0;
      pack_d = '0;
    end else if (in_en) begin
      idx_d  = idx_q + IDXW'(1);
      pack_d = word_fill;
    end
  end

  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign fifo_full = (level_q == LW'(DEPTH));
  assign pop       = (level_q != '0) && o_tready;
  assign push_ok   = push && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    ovf_d  = ovf_q | (push && !push_ok);
    bcnt_d = in_en ? bcnt_q + 32'd1 : bcnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      pack_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      bcnt_q   <= '0;
    end else begin
      idx_q    <= idx_d;
      pack_q   <= pack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      bcnt_q   <= bcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr_q] <= {flush, word_push};
    end
  end

  // Head is gated so the data bus reads zero whenever nothing is queued.
  assign o_tvalid            = (level_q != '0);
  assign {o_tlast, o_tdata}  = o_tvalid ? mem[rd_ptr_q] : '0;
  assign fifo_level          = level_q;
  assign overflow            = ovf_q;
  assign byte_count          = bcnt_q;

`ifdef SD_PACK_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  assign csum_d = in_en ? csum_q + in_byte : csum_q;

  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_sd_stream_packer.sv
// Bench for sd_stream_packer: two instances (little-endian/C3 pad, big-endian/00 pad) share
// stimulus and are compared every cycle against a queue-based reference model.
module tb_sd_stream_packer;

  localparam int WB    = 4;
  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_en = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        flush = 1'b0;
  logic        o_tready = 1'b0;

  logic        a_tvalid, a_tlast, a_ovf;
  logic [31:0] a_tdata, a_bc;
  logic [DL:0] a_level;
  logic        b_tvalid, b_tlast, b_ovf;
  logic [31:0] b_tdata, b_bc;
  logic [DL:0] b_level;
`ifdef SD_PACK_CHECKSUM_EN
  logic [7:0]  a_cs, b_cs;
`endif

  sd_stream_packer #(.WORD_BYTES(WB), .FIFO_DEPTH_LOG2(DL), .BIG_ENDIAN(1'b0), .PAD_BYTE(8'hC3)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_byte(in_byte), .flush(flush),
    .o_tvalid(a_tvalid), .o_tready(o_tready), .o_tdata(a_tdata), .o_tlast(a_tlast),
    .fifo_level(a_level), .overflow(a_ovf), .byte_count(a_bc)
`ifdef SD_PACK_CHECKSUM_EN
    , .checksum(a_cs)
`endif
  );

  sd_stream_packer #(.WORD_BYTES(WB), .FIFO_DEPTH_LOG2(DL), .BIG_ENDIAN(1'b1), .PAD_BYTE(8'h00)) dut_be (
    .clk(clk), .rst(rst), .in_en(in_en), .in_byte(in_byte), .flush(flush),
    .o_tvalid(b_tvalid), .o_tready(o_tready), .o_tdata(b_tdata), .o_tlast(b_tlast),
    .fifo_level(b_level), .overflow(b_ovf), .byte_count(b_bc)
`ifdef SD_PACK_CHECKSUM_EN
    , .checksum(b_cs)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: bytes of the open word, then the queued words in arrival order.
  logic [7:0]  cur[$];
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  bit          ql[$];
  bit          m_ovf = 1'b0;
  logic [31:0] m_bc = '0;
  logic [7:0]  m_cs = '0;

  function automatic logic [31:0] build(input bit be, input logic [7:0] pad);
    logic [31:0] w;
    logic [7:0]  b;
    w = '0;
    for (int i = 0; i < WB; i++) begin
      b = (i < cur.size()) ? cur[i] : pad;
      if (be) w[8*(WB-1-i) +: 8] = b;
      else    w[8*i +: 8] = b;
    end
    return w;
  endfunction

  task automatic model_edge();
    bit do_pop;
    bit was_full;
    if (rst) begin
      cur.delete(); qa.delete(); qb.delete(); ql.delete();
      m_ovf = 1'b0; m_bc = '0; m_cs = '0;
      return;
    end
    do_pop   = (qa.size() != 0) && o_tready;
    was_full = (qa.size() == DEPTH);
    if (in_en) begin
      cur.push_back(in_byte);
      m_bc = m_bc + 32'd1;
      m_cs = m_cs + in_byte;
    end
    if (cur.size() == WB || flush) begin
      if (!was_full || do_pop) begin
        qa.push_back(build(1'b0, 8'hC3));
        qb.push_back(build(1'b1, 8'h00));
        ql.push_back(flush);
      end else begin
        m_ovf = 1'b1;
      end
      cur.delete();
    end
    if (do_pop) begin
      void'(qa.pop_front()); void'(qb.pop_front()); void'(ql.pop_front());
    end
  endtask

  task automatic compare();
    chk("tvalid_a", 64'(a_tvalid), 64'(qa.size() != 0));
    chk("tvalid_b", 64'(b_tvalid), 64'(qb.size() != 0));
    chk("level_a", 64'(a_level), 64'(qa.size()));
    chk("level_b", 64'(b_level), 64'(qb.size()));
    chk("ovf_a", 64'(a_ovf), 64'(m_ovf));
    chk("ovf_b", 64'(b_ovf), 64'(m_ovf));
    chk("bcount_a", 64'(a_bc), 64'(m_bc));
    chk("bcount_b", 64'(b_bc), 64'(m_bc));
    if (qa.size() != 0) begin
      chk("tdata_a", 64'(a_tdata), 64'(qa[0]));
      chk("tdata_b", 64'(b_tdata), 64'(qb[0]));
      chk("tlast_a", 64'(a_tlast), 64'(ql[0]));
      chk("tlast_b", 64'(b_tlast), 64'(ql[0]));
    end
`ifdef SD_PACK_CHECKSUM_EN
    chk("csum_a", 64'(a_cs), 64'(m_cs));
    chk("csum_b", 64'(b_cs), 64'(m_cs));
`endif
  endtask

  task automatic step(input bit en, input logic [7:0] b, input bit fl, input bit rdy);
    in_en = en; in_byte = b; flush = fl; o_tready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit rdy_mode;
    do_reset();
    chk("rst_tvalid", 64'(a_tvalid), 64'(0));
    chk("rst_level", 64'(a_level), 64'(0));
    chk("rst_tdata", 64'(a_tdata), 64'(0));
    chk("rst_bcount", 64'(b_bc), 64'(0));

    // One full little-endian word, valid one cycle after the fourth byte.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    chk("t2_not_yet", 64'(a_tvalid), 64'(0));
    step(1'b1, 8'h44, 1'b0, 1'b0);
    chk("t2_tvalid", 64'(a_tvalid), 64'(1));
    chk("t2_tdata", 64'(a_tdata), 64'h44332211);
    chk("t2_tlast", 64'(a_tlast), 64'(0));
    chk("t2_tdata_be", 64'(b_tdata), 64'h11223344);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Partial word flush and empty flush.
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_be_data", 64'(b_tdata), 64'hAABB0000);
    chk("t3_be_last", 64'(b_tlast), 64'(1));
    chk("t3_le_pad", 64'(a_tdata), 64'hC3C3BBAA);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_empty_be", 64'(b_tdata), 64'h00000000);
    chk("t3_empty_last", 64'(b_tlast), 64'(1));
    chk("t3_empty_le", 64'(a_tdata), 64'hC3C3C3C3);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    // Byte and flush together complete a word.
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    step(1'b1, 8'h04, 1'b1, 1'b0);
    chk("t3_full_flush", 64'(a_tdata), 64'h04030201);
    chk("t3_full_last", 64'(a_tlast), 64'(1));
    chk("t3_one_word", 64'(a_level), 64'(1));
    drain();

    // 17 words into a 16-deep FIFO with no drain.
    do_reset();
    for (int w = 0; w < 17; w++)
      for (int k = 0; k < 4; k++) step(1'b1, 8'(w*4 + k + 1), 1'b0, 1'b0);
    chk("t4_level", 64'(a_level), 64'(16));
    chk("t4_ovf", 64'(a_ovf), 64'(1));
    chk("t4_bcount", 64'(a_bc), 64'(68));
    chk("t4_head", 64'(a_tdata), 64'h04030201);
    drain();
    chk("t4_ovf_sticky", 64'(a_ovf), 64'(1));

    // Full FIFO, completing byte coincides with a pop.
    do_reset();
    for (int w = 0; w < 16; w++)
      for (int k = 0; k < 4; k++) step(1'b1, 8'(w*4 + k + 1), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 8'(8'hE0 + k), 1'b0, 1'b0);
    step(1'b1, 8'hE3, 1'b0, 1'b1);
    chk("t5_ovf", 64'(a_ovf), 64'(0));
    chk("t5_level", 64'(a_level), 64'(16));
    chk("t5_head", 64'(a_tdata), 64'h08070605);
    drain();

    // Reset in the middle of a word leaves no stale lanes.
    do_reset();
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b1, 8'h88, 1'b0, 1'b0);
    do_reset();
    for (int k = 1; k <= 4; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
    chk("t6_tdata", 64'(a_tdata), 64'h04030201);
`ifdef SD_PACK_CHECKSUM_EN
    chk("t6_csum", 64'(a_cs), 64'h0A);
`endif
    drain();

    // Randomized traffic with alternating slow and fast drain phases.
    rdy_mode = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 80 == 0) rdy_mode = ~rdy_mode;
      rst = ($urandom_range(0, 599) == 0);
      step($urandom_range(0, 99) < 70, 8'($urandom),
           $urandom_range(0, 99) < 6,
           rdy_mode ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 15));
    end
    rst = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
